// File: rtl/core_bus_master.sv
// -----------------------------------------------------------------------------
// core_bus_master
//
// Bus-side partner of the core register file's bus register. Accepts one
// load/store request at a time from the core and runs a req/ack transaction on
// the memory bus. Load data comes back on bus_datain together with a one-cycle
// bus_fromin strobe. A store completes with a one-cycle wr_done strobe. If the
// memory does not acknowledge within TIMEOUT cycles, the request is aborted.
// An abort pulses bus_err and bus_fromin together and returns all-ones data.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_addr/req_wdata  request address / store data
//   busy                high while a transaction is open (state != IDLE)
//   bus_datain          load result, held between loads
//   bus_fromin          one-cycle strobe: bus_datain valid
//   wr_done             one-cycle strobe: store acknowledged
//   bus_err             one-cycle strobe: transaction aborted by timeout
//   mem_addr/mem_wdata  registered address / store data to memory
//   mem_re/mem_we       read / write request, held until ack or abort
//   mem_rdata/mem_ack   memory read data and completion
// -----------------------------------------------------------------------------
module core_bus_master #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              busy,
    output logic [DATA_W-1:0] bus_datain,
    output logic              bus_fromin,
    output logic              wr_done,
    output logic              bus_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    // A disabled timeout still needs a legal one-bit counter.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam bit TO_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               write_q, write_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               re_q, re_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  datain_q, datain_d;
    logic               fromin_q, fromin_d;
    logic               wr_done_q, wr_done_d;
    logic               err_q, err_d;

    logic [CNT_W-1:0]   cnt_next_s;
    logic               timeout_hit_s;

    // Saturating wait counter. The abort fires in the ACCESS cycle whose count
    // reaches TIMEOUT, so TIMEOUT unacknowledged ACCESS cycles are allowed.
    always_comb begin
        if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_next_s = cnt_q;
        end else begin
            cnt_next_s = cnt_q + CNT_W'(1);
        end
        timeout_hit_s = TO_EN && (cnt_next_s == TO_VAL);
    end

    // Next-state and datapath decode for the IDLE -> ACCESS -> DONE sequence.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        re_d      = re_q;
        we_d      = we_q;
        datain_d  = datain_q;
        fromin_d  = 1'b0;
        wr_done_d = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // mem_ack is deliberately ignored here.
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    re_d    = !req_write;
                    we_d    = req_write;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // An acknowledge takes priority over a timeout in the same cycle.
                if (mem_ack) begin
                    re_d      = 1'b0;
                    we_d      = 1'b0;
                    fromin_d  = !write_q;
                    wr_done_d = write_q;
                    if (!write_q) begin
                        datain_d = mem_rdata;
                    end else begin
                        datain_d = datain_q;
                    end
                    state_d = ST_DONE;
                end else if (timeout_hit_s) begin
                    re_d     = 1'b0;
                    we_d     = 1'b0;
                    datain_d = {DATA_W{1'b1}};
                    fromin_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_next_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                re_d    = 1'b0;
                we_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            datain_q  <= {DATA_W{1'b0}};
            fromin_q  <= 1'b0;
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            re_q      <= re_d;
            we_q      <= we_d;
            datain_q  <= datain_d;
            fromin_q  <= fromin_d;
            wr_done_q <= wr_done_d;
            err_q     <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign bus_datain = datain_q;
    assign bus_fromin = fromin_q;
    assign wr_done    = wr_done_q;
    assign bus_err    = err_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_re     = re_q;
    assign mem_we     = we_q;

endmodule

// File: tb/tb_core_bus_master.sv
module tb_core_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, busy;
    logic [15:0] bus_datain;
    logic        bus_fromin, wr_done, bus_err;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_re, mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    core_bus_master #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .busy(busy),
        .bus_datain(bus_datain), .bus_fromin(bus_fromin),
        .wr_done(wr_done), .bus_err(bus_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fromin;
        logic        wrd;
        logic        err;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] last_data = 16'h0000;
    logic [15:0] exp_addr = 16'h0000;
    int          busy_cyc = 0, re_cyc = 0, we_cyc = 0, acc_cnt = 0, strobe_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: activity counters, address stability and scoreboard pops on strobes.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cyc++;
        if (mem_re === 1'b1) re_cyc++;
        if (mem_we === 1'b1) we_cyc++;
        if (req_valid === 1'b1 && req_ready === 1'b1) acc_cnt++;
        if (mem_re === 1'b1 || mem_we === 1'b1) chk("addr_hold", 32'(mem_addr), 32'(exp_addr));
        if (bus_fromin !== 1'b0 || wr_done !== 1'b0 || bus_err !== 1'b0) begin
            exp_t e;
            strobe_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("bus_fromin", 32'(bus_fromin), 32'(e.fromin));
                chk("wr_done", 32'(wr_done), 32'(e.wrd));
                chk("bus_err", 32'(bus_err), 32'(e.err));
                chk("bus_datain", 32'(bus_datain), 32'(e.data));
            end
        end
    end

    task automatic clear_counts();
        busy_cyc = 0; re_cyc = 0; we_cyc = 0; acc_cnt = 0; strobe_cnt = 0;
    endtask

    // One transaction from IDLE; returns at posedge+1 back in IDLE.
    task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata, input int waits, input bit no_ack);
        exp_t e;
        int   n;
        if (no_ack)   begin e = '{1'b1, 1'b0, 1'b1, 16'hFFFF}; last_data = 16'hFFFF; end
        else if (wr)  begin e = '{1'b0, 1'b1, 1'b0, last_data}; end
        else          begin e = '{1'b1, 1'b0, 1'b0, rdata}; last_data = rdata; end
        sb.push_back(e);
        exp_addr  = addr;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 16'hDEAD; req_wdata = 16'hDEAD;
        chk("mem_re_start", 32'(mem_re), 32'(!wr));
        chk("mem_we_start", 32'(mem_we), 32'(wr));
        if (wr) chk("mem_wdata", 32'(mem_wdata), 32'(wdata));
        if (no_ack) begin
            n = 0;
            while (busy === 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
            chk("timeout_bound", 32'(n < 400), 32'd1);
        end else begin
            repeat (waits) begin @(posedge clk); #1; end
            mem_ack = 1'b1; mem_rdata = rdata;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 16'h5555;
            chk("done_ready_low", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0000;
        req_wdata = 16'h0000; mem_rdata = 16'h0000; mem_ack = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {mem_re, mem_we, bus_fromin, wr_done, bus_err}, 32'd0);
        chk("rst_data", {mem_addr, bus_datain}, 32'd0);

        // Load with one wait state.
        clear_counts();
        do_req(1'b0, 16'h0100, 16'h0000, 16'hBEEF, 1, 1'b0);
        chk("t1_busy_cycles", 32'(busy_cyc), 32'd3);
        chk("t1_re_cycles", 32'(re_cyc), 32'd2);

        // Store with five wait states.
        clear_counts();
        do_req(1'b1, 16'h8000, 16'h1234, 16'h0000, 5, 1'b0);
        chk("t2_we_cycles", 32'(we_cyc), 32'd6);
        chk("t2_datain_kept", 32'(bus_datain), 32'h0000BEEF);

        // Timeout abort, then ack in the last allowed cycle.
        clear_counts();
        do_req(1'b0, 16'h0200, 16'h0000, 16'h0000, 0, 1'b1);
        chk("t3_re_cycles", 32'(re_cyc), 32'd255);
        chk("t3_datain_ff", 32'(bus_datain), 32'h0000FFFF);
        clear_counts();
        do_req(1'b0, 16'h0204, 16'h0000, 16'h5A5A, 254, 1'b0);
        chk("t3b_re_cycles", 32'(re_cyc), 32'd255);

        // req_valid held high with mem_ack always high.
        clear_counts();
        repeat (4) sb.push_back('{1'b1, 1'b0, 1'b0, 16'h7777});
        last_data = 16'h7777;
        exp_addr = 16'h0040;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        repeat (12) @(posedge clk); #1;
        req_valid = 1'b0; mem_ack = 1'b0;
        chk("t4_accepts", 32'(acc_cnt), 32'd4);
        chk("t4_strobes", 32'(strobe_cnt), 32'd4);
        chk("t4_busy_cycles", 32'(busy_cyc), 32'd8);
        // Stray ack in IDLE.
        clear_counts();
        mem_ack = 1'b1; mem_rdata = 16'h0BAD;
        repeat (3) @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("t4_stray_strobes", 32'(strobe_cnt), 32'd0);
        chk("t4_stray_busy", 32'(busy_cyc), 32'd0);
        chk("t4_stray_datain", 32'(bus_datain), 32'h00007777);

        // Reset during ACCESS together with mem_ack.
        clear_counts();
        exp_addr = 16'h0300;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0300;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t5_in_access", 32'(mem_re), 32'd1);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h1111;
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b0;
        last_data = 16'h0000;
        chk("t5_ready", 32'(req_ready), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_outs", {mem_re, mem_we, bus_fromin, wr_done, bus_err}, 32'd0);
        chk("t5_data", {mem_addr, bus_datain}, 32'd0);
        repeat (3) @(posedge clk); #1;
        chk("t5_no_strobe", 32'(strobe_cnt), 32'd0);

        // Back-to-back load then store.
        clear_counts();
        do_req(1'b0, 16'h0001, 16'h0000, 16'hA001, 0, 1'b0);
        do_req(1'b1, 16'h0002, 16'hC0DE, 16'h0000, 0, 1'b0);
        repeat (2) @(posedge clk); #1;
        chk("t6_strobes", 32'(strobe_cnt), 32'd2);
        chk("t6_datain", 32'(bus_datain), 32'h0000A001);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
